// File: rtl/button_strip_ctrl.sv
// Big-button puzzle sequencer: debounces the button, classifies tap/hold, drives the
// RGB strip during a hold and checks the release against the rule and timer digits.
module button_strip_ctrl #(
  parameter int DEB_CYCLES  = 50000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int TICK_DIV    = 600
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       btn,
  input  logic       rule_hold,
  input  logic [9:0] digit_mask,
  output logic [2:0] color,
  output logic       strip_on,
  output logic       solved,
  output logic       strike,
  output logic       busy
);

  localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, PRESS, HOLD, DONE} state_t;

  state_t        state, state_next;
  logic          sync1, sync2;
  logic          btn_db, btn_db_d;
  logic [DW-1:0] deb_cnt;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    lfsr;
  logic [HW-1:0] hold_cnt, hold_cnt_next;
  logic          hold_req, hold_req_next;
  logic [2:0]    color_next;
  logic          strip_next, solved_next, strike_next, busy_next;
  logic          rise, fall;
  logic [3:0]    req_digit;

  // NOTE: every clocked process uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // The level flips only after DEB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_db_d <= btn_db;
      if (sync2 == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_db  <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign rise = btn_db & ~btn_db_d;
  assign fall = ~btn_db & btn_db_d;

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1, stepped once per TICK_DIV cycles.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lfsr     <= 8'hA5;
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Release digit demanded by the strip colour.
  always_comb begin
    case (color)
      3'b001:  req_digit = 4'd4;
      3'b111:  req_digit = 4'd1;
      3'b110:  req_digit = 4'd5;
      default: req_digit = 4'd1;
    endcase
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    hold_req_next = hold_req;
    color_next    = color;
    strip_next    = strip_on;
    solved_next   = solved;
    strike_next   = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          state_next    = PRESS;
          hold_cnt_next = '0;
          hold_req_next = rule_hold;
        end
      end
      PRESS: begin
        if (fall) begin
          if (!hold_req) begin
            state_next  = DONE;
            solved_next = 1'b1;
          end else begin
            state_next  = IDLE;
            strike_next = 1'b1;
          end
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = HOLD;
          color_next = (lfsr[2:0] == 3'b000) ? 3'b111 : lfsr[2:0];
          strip_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (fall) begin
          strip_next = 1'b0;
          color_next = 3'b000;
          if (hold_req && digit_mask[req_digit]) begin
            state_next  = DONE;
            solved_next = 1'b1;
          end else begin
            state_next  = IDLE;
            strike_next = 1'b1;
          end
        end
      end
      DONE: begin
        solved_next = 1'b1;
        strip_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == PRESS) || (state_next == HOLD);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      hold_req <= 1'b0;
      color    <= 3'b000;
      strip_on <= 1'b0;
      solved   <= 1'b0;
      strike   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
      hold_req <= hold_req_next;
      color    <= color_next;
      strip_on <= strip_next;
      solved   <= solved_next;
      strike   <= strike_next;
      busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_button_strip_ctrl.sv
// Bench for button_strip_ctrl: table of press scenarios with an event scoreboard,
// plus hand-written bounce, reset-mid-hold and solved-lockout sequences.
module tb_button_strip_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       btn;
  logic       rule_hold;
  logic [9:0] digit_mask;
  logic [2:0] color;
  logic       strip_on, solved, strike, busy;

  button_strip_ctrl #(.DEB_CYCLES(4), .HOLD_CYCLES(20), .TICK_DIV(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .btn(btn), .rule_hold(rule_hold), .digit_mask(digit_mask),
    .color(color), .strip_on(strip_on), .solved(solved), .strike(strike), .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef enum int {EV_SOLVED, EV_STRIKE} ev_t;

  typedef struct {
    logic       rule;
    int         len;
    logic [9:0] mask;
    logic       force_en;
    logic [7:0] lfsr_val;
    logic       exp_solved;
    int         exp_strikes;
    logic       exp_strip;
    logic       chk_color;
    logic [2:0] exp_color;
  } vec_t;

  vec_t vecs[12];
  ev_t  exp_q[$];

  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  int         strike_cycles;
  logic       strip_seen, busy_seen, solved_prev;
  logic [2:0] color_seen;
  logic [7:0] force_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic handle_event(input ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s expected none", got.name());
    end else begin
      e = exp_q.pop_front();
      if (e != got) begin
        errors++;
        $display("FAIL event_kind: got %s expected %s", got.name(), e.name());
      end
    end
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      if (strip_on) begin
        strip_seen = 1'b1;
        color_seen = color;
      end
      if (busy) busy_seen = 1'b1;
      if (strike) begin
        strike_cycles++;
        handle_event(EV_STRIKE);
      end
      if (solved && !solved_prev) handle_event(EV_SOLVED);
      solved_prev = solved;
    end
  end

  task automatic clear_stats();
    strike_cycles = 0;
    strip_seen    = 1'b0;
    busy_seen     = 1'b0;
    color_seen    = 3'b000;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b0;
    btn   = 1'b0;
    repeat (2) @(negedge Clk);
    clear_stats();
    solved_prev = 1'b0;
    exp_q.delete();
    Rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(negedge Clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic press(input int len);
    btn = 1'b1;
    repeat (len) @(negedge Clk);
    btn = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         rule len mask            frc lfsr   sol str strip chkc color
    vecs[0]  = '{1'b0, 10, 10'b0000000000, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 3'b000};
    vecs[1]  = '{1'b1, 10, 10'b0000000000, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 3'b000};
    vecs[2]  = '{1'b1, 40, 10'b0000010000, 1'b1, 8'h01, 1'b1, 0, 1'b1, 1'b1, 3'b001};
    vecs[3]  = '{1'b1, 40, 10'b0000000010, 1'b1, 8'h01, 1'b0, 1, 1'b1, 1'b1, 3'b001};
    vecs[4]  = '{1'b1, 40, 10'b0000000010, 1'b1, 8'h08, 1'b1, 0, 1'b1, 1'b1, 3'b111};
    vecs[5]  = '{1'b1, 40, 10'b0000100000, 1'b1, 8'h06, 1'b1, 0, 1'b1, 1'b1, 3'b110};
    vecs[6]  = '{1'b1, 40, 10'b0000010000, 1'b1, 8'h06, 1'b0, 1, 1'b1, 1'b1, 3'b110};
    vecs[7]  = '{1'b1, 40, 10'b0000000010, 1'b1, 8'h04, 1'b1, 0, 1'b1, 1'b1, 3'b100};
    vecs[8]  = '{1'b0, 40, 10'b0000010000, 1'b1, 8'h01, 1'b0, 1, 1'b1, 1'b1, 3'b001};
    vecs[9]  = '{1'b0, 20, 10'b0000000000, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 3'b000};
    vecs[10] = '{1'b1, 20, 10'b1111111111, 1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 3'b000};
    vecs[11] = '{1'b1, 21, 10'b1111111111, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 3'b000};

    btn        = 1'b0;
    rule_hold  = 1'b0;
    digit_mask = '0;
    force_val  = 8'h00;
    Rst_n      = 1'b0;
    do_reset();

    // Reset state
    @(negedge Clk);
    check("rst_color", color, 3'b000);
    check("rst_strip", strip_on, 1'b0);
    check("rst_solved", solved, 1'b0);
    check("rst_strike", strike, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_lfsr", dut.lfsr, 8'hA5);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      rule_hold  = vecs[i].rule;
      digit_mask = vecs[i].mask;
      if (vecs[i].force_en) begin
        force_val = vecs[i].lfsr_val;
        force dut.lfsr = force_val;
      end
      exp_q.push_back(vecs[i].exp_solved ? EV_SOLVED : EV_STRIKE);
      press(vecs[i].len);
      wait_drain($sformatf("v%0d_event", i));
      repeat (5) @(negedge Clk);
      if (vecs[i].force_en) release dut.lfsr;
      check($sformatf("v%0d_solved", i), solved, vecs[i].exp_solved);
      check($sformatf("v%0d_strikes", i), strike_cycles, vecs[i].exp_strikes);
      check($sformatf("v%0d_strip_seen", i), strip_seen, vecs[i].exp_strip);
      check($sformatf("v%0d_strip_end", i), strip_on, 1'b0);
      check($sformatf("v%0d_busy_end", i), busy, 1'b0);
      if (vecs[i].chk_color) check($sformatf("v%0d_color", i), color_seen, vecs[i].exp_color);
    end

    // Bounce: toggles every 2 cycles never outlast the debouncer
    do_reset();
    rule_hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      btn = ~btn;
      repeat (2) @(negedge Clk);
    end
    btn = 1'b0;
    repeat (30) @(negedge Clk);
    check("bounce_busy", busy_seen, 1'b0);
    check("bounce_strikes", strike_cycles, 0);
    check("bounce_solved", solved, 1'b0);

    // Reset asserted while in HOLD
    do_reset();
    rule_hold  = 1'b1;
    digit_mask = 10'b1111111111;
    btn        = 1'b1;
    repeat (32) @(negedge Clk);
    check("mid_hold_strip", strip_on, 1'b1);
    check("mid_hold_busy", busy, 1'b1);
    mon_en = 1'b0;
    Rst_n  = 1'b0;
    btn    = 1'b0;
    #1;
    check("rh_color", color, 3'b000);
    check("rh_strip", strip_on, 1'b0);
    check("rh_strike", strike, 1'b0);
    check("rh_solved", solved, 1'b0);
    check("rh_busy", busy, 1'b0);
    check("rh_lfsr", dut.lfsr, 8'hA5);
    @(negedge Clk);
    clear_stats();
    solved_prev = 1'b0;
    Rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (40) @(negedge Clk);
    check("rh_after_strikes", strike_cycles, 0);
    check("rh_after_busy", busy_seen, 1'b0);
    check("rh_after_solved", solved, 1'b0);

    // Once solved, further presses are ignored and solved stays set
    do_reset();
    rule_hold = 1'b0;
    exp_q.push_back(EV_SOLVED);
    press(10);
    wait_drain("done_event");
    repeat (3) @(negedge Clk);
    clear_stats();
    press(40);
    repeat (20) @(negedge Clk);
    check("done_busy", busy_seen, 1'b0);
    check("done_strip", strip_seen, 1'b0);
    check("done_strikes", strike_cycles, 0);
    check("done_solved", solved, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
